// File: rtl/seq_detect_gate.sv
// Serial sync-pattern hunter that gates a fixed-length payload frame
// onto a registered serial output after each detected pattern.
module seq_detect_gate #(
    parameter int                PAT_W     = 6,
    parameter logic [PAT_W-1:0]  PATTERN   = 6'b011110,
    parameter int                FRAME_LEN = 1024,
    parameter int                CNT_W     = $clog2(FRAME_LEN + 1),
    // Ceiling for match_cnt; lowered only to exercise saturation quickly.
    parameter logic [15:0]       MATCH_SAT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        serIn,
    output logic        serOut,
    output logic        serOutValid,
    output logic        frame_done,
    output logic [15:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [PAT_W-1:0]   hist;
    logic [PAT_W-1:0]   hist_n;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_n;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_cnt_n;
    logic               out_q;
    logic               out_n;
    logic               valid_q;
    logic               valid_n;
    logic               done_q;
    logic               done_n;
    logic [15:0]        mcnt_q;
    logic [15:0]        mcnt_n;

    logic [PAT_W-1:0]   window;
    logic               match;
    logic               last_bit;

    // Candidate pattern: stored history plus the bit arriving this edge.
    always_comb begin
        window = {hist[PAT_W-2:0], serIn};
        match  = en && (fill >= FILL_LAST) && (window == PATTERN);
    end

    // Final payload bit is forwarded on this edge.
    always_comb begin
        last_bit = (state == PAYLOAD) && en && (frame_cnt == CNT_LAST);
    end

    // Next-state, history, frame counter and output computation.
    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_n      = fill;
        frame_cnt_n = frame_cnt;
        out_n       = 1'b0;
        valid_n     = 1'b0;
        mcnt_n      = mcnt_q;
        // valid is only ever high in HUNT on the cycle right after the
        // final payload bit, so it marks exactly when the pulse is due.
        done_n      = (state == HUNT) && valid_q;

        unique case (state)
            HUNT: begin
                if (en) begin
                    hist_n = window;
                    if (fill != FILL_FULL) begin
                        fill_n = fill + 1'b1;
                    end
                end
                if (match) begin
                    state_n     = PAYLOAD;
                    hist_n      = '0;
                    fill_n      = '0;
                    frame_cnt_n = '0;
                    if (mcnt_q != MATCH_SAT) begin
                        mcnt_n = mcnt_q + 16'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (en) begin
                    out_n   = serIn;
                    valid_n = 1'b1;
                    if (last_bit) begin
                        state_n     = HUNT;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            frame_cnt <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill      <= fill_n;
            frame_cnt <= frame_cnt_n;
            out_q     <= out_n;
            valid_q   <= valid_n;
            done_q    <= done_n;
            mcnt_q    <= mcnt_n;
        end
    end

    assign serOut      = out_q;
    assign serOutValid = valid_q;
    assign frame_done  = done_q;
    assign match_cnt   = mcnt_q;

endmodule

// File: tb/tb_seq_detect_gate.sv
// Directed self-checking bench for seq_detect_gate with an 8-bit frame
// and a second instance whose match counter saturates at 3.
module tb_seq_detect_gate;

    logic        clk;
    logic        rst;
    logic        en;
    logic        serIn;
    logic        serOut;
    logic        serOutValid;
    logic        frame_done;
    logic [15:0] match_cnt;

    logic        s_out;
    logic        s_valid;
    logic        s_done;
    logic [15:0] s_mcnt;

    int          checks;
    int          errors;
    logic [15:0] exp_mc;
    logic [15:0] exp_smc;
    logic [5:0]  pat;
    logic [9:0]  near;
    logic [7:0]  pl;
    int          nvalid;

    seq_detect_gate #(
        .PAT_W    (6),
        .PATTERN  (6'b011110),
        .FRAME_LEN(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .serIn      (serIn),
        .serOut     (serOut),
        .serOutValid(serOutValid),
        .frame_done (frame_done),
        .match_cnt  (match_cnt)
    );

    seq_detect_gate #(
        .PAT_W    (6),
        .PATTERN  (6'b011110),
        .FRAME_LEN(8),
        .MATCH_SAT(16'd3)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .serIn      (serIn),
        .serOut     (s_out),
        .serOutValid(s_valid),
        .frame_done (s_done),
        .match_cnt  (s_mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en    = e;
        serIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pat(input string tag);
        pat = 6'b011110;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pat[5-i]);
            chk({tag, "_hunt_vld"}, serOutValid, 1'b0);
            chk({tag, "_hunt_out"}, serOut, 1'b0);
        end
        exp_mc++;
        chk({tag, "_mcnt"}, match_cnt, exp_mc);
    endtask

    task automatic payload(input string tag, input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, p[7-i]);
            chk({tag, "_out"}, serOut, p[7-i]);
            chk({tag, "_vld"}, serOutValid, 1'b1);
            chk({tag, "_early_done"}, frame_done, 1'b0);
        end
        step(1'b1, 1'b0);
        chk({tag, "_vld_fall"}, serOutValid, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b1);
        chk({tag, "_out_zero"}, serOut, 1'b0);
        step(1'b1, 1'b0);
        chk({tag, "_done_1cyc"}, frame_done, 1'b0);
        chk({tag, "_mcnt_hold"}, match_cnt, exp_mc);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_mc  = 16'd0;
        exp_smc = 16'd0;
        rst     = 1'b0;
        en      = 1'b0;
        serIn   = 1'b0;

        #3;
        chk("rst_out", serOut, 1'b0);
        chk("rst_vld", serOutValid, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_mcnt", match_cnt, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic frame.
        send_pat("basic");
        payload("basic", 8'b10110010);

        // Pattern embedded in payload must be ignored.
        send_pat("inpl");
        payload("inpl", 8'b01111011);

        // Three-cycle en pause after payload bit 4.
        send_pat("pause");
        exp_smc = 16'd3;
        chk("pause_sat_mcnt", s_mcnt, exp_smc);
        pl     = 8'b11010110;
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pl[7-i]);
            chk("pause_out", serOut, pl[7-i]);
            if (serOutValid) nvalid++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("pause_vld_low", serOutValid, 1'b0);
            chk("pause_out_low", serOut, 1'b0);
            chk("pause_no_done", frame_done, 1'b0);
        end
        for (int i = 4; i < 8; i++) begin
            step(1'b1, pl[7-i]);
            chk("pause_out", serOut, pl[7-i]);
            chk("pause_no_done", frame_done, 1'b0);
            if (serOutValid) nvalid++;
        end
        chk("pause_nvalid", nvalid, 8);
        step(1'b1, 1'b0);
        chk("pause_vld_fall", serOutValid, 1'b0);
        chk("pause_done", frame_done, 1'b1);
        step(1'b1, 1'b0);
        chk("pause_done_1cyc", frame_done, 1'b0);

        // Reset mid-frame after payload bit 5.
        send_pat("rstm");
        pl = 8'b11111111;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pl[7-i]);
        end
        chk("rstm_pre_vld", serOutValid, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstm_out", serOut, 1'b0);
        chk("rstm_vld", serOutValid, 1'b0);
        chk("rstm_done", frame_done, 1'b0);
        chk("rstm_mcnt", match_cnt, 16'd0);
        chk("rstm_sat_mcnt", s_mcnt, 16'd0);
        exp_mc  = 16'd0;
        exp_smc = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            chk("rstm_hold_done", frame_done, 1'b0);
            chk("rstm_hold_vld", serOutValid, 1'b0);
        end
        rst = 1'b1;
        send_pat("after_rst");
        payload("after_rst", 8'b00110101);

        // Near-miss followed by an overlapping hit on the final 0.
        near = 10'b0111011110;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, near[9-i]);
            chk("near_no_match", match_cnt, exp_mc);
            chk("near_vld", serOutValid, 1'b0);
        end
        step(1'b1, near[0]);
        exp_mc++;
        chk("near_match", match_cnt, exp_mc);
        payload("near", 8'b11110000);

        // Saturation on the low-ceiling instance.
        chk("sat_two", s_mcnt, 16'd2);
        send_pat("satA");
        chk("sat_three", s_mcnt, 16'd3);
        payload("satA", 8'b00000000);
        send_pat("satB");
        chk("sat_hold", s_mcnt, 16'd3);
        payload("satB", 8'b10000001);
        chk("sat_final_mcnt", s_mcnt, 16'd3);
        chk("sat_final_vld", s_valid, 1'b0);
        chk("sat_final_done", s_done, 1'b0);
        chk("sat_final_out", s_out, 1'b0);
        chk("main_final_mcnt", match_cnt, 16'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_gate.md
SEQ_DETECT_GATE -- requirements
Module: seq_detect_gate

Interface
REQ-001 The block SHALL have the following parameters, given as name, default and meaning:
- PAT_W, 6: sync pattern length in bits, valid range 2..32.
- PATTERN, 6'b011110: sync pattern; bit PAT_W-1 is the oldest (first received) bit.
- FRAME_LEN, 1024: number of payload bits forwarded per detected pattern, valid range 1..65535.
- CNT_W, $clog2(FRAME_LEN+1): width of the frame counter.

REQ-002 The block SHALL have the following ports, given as name, direction, width and meaning:
- clk, input, 1: the only clock; all flops update on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: sample enable; serIn is ignored while en=0.
- serIn, input, 1: serial data input.
- serOut, output, 1: registered payload bit; 0 whenever serOutValid=0.
- serOutValid, output, 1: serOut carries a payload bit this cycle.
- frame_done, output, 1: one-cycle pulse after the last payload bit is forwarded.
- match_cnt, output, 16: saturating count of detected patterns.

REQ-003 serOut SHALL never be driven to high impedance.

Function
REQ-004 The block SHALL be a two-state machine with states HUNT and PAYLOAD; the reset state is HUNT.
REQ-005 In HUNT, on each clock edge with en=1, serIn SHALL be shifted into a PAT_W-bit history register at the LSB, and a fill count (saturating at PAT_W) SHALL be incremented.
REQ-006 A match SHALL be declared when the fill count is at least PAT_W-1, en=1, and {history[PAT_W-2:0], serIn} == PATTERN.
REQ-007 On a match, the edge that samples the final pattern bit SHALL move the state to PAYLOAD, clear the frame counter to 0, and increment match_cnt; match_cnt holds at 16'hFFFF once it saturates.
REQ-008 In PAYLOAD, on each edge with en=1:
- serOut SHALL be loaded with serIn.
- serOutValid SHALL be set to 1.
- The frame counter SHALL be incremented.
REQ-009 In PAYLOAD, on each edge with en=0, serOutValid and serOut SHALL be set to 0 and the frame counter SHALL hold; a pause SHALL NOT shorten the frame.
REQ-010 When the frame counter reaches FRAME_LEN-1 and en=1, that edge SHALL forward the final bit and return the state to HUNT. On the next edge, serOutValid SHALL fall and frame_done SHALL pulse high for exactly one cycle.
REQ-011 The first payload bit SHALL be the serIn bit sampled on the edge after the final pattern bit; payload latency from serIn to serOut is one cycle.
REQ-012 Exactly FRAME_LEN bits with serOutValid=1 SHALL be emitted per match.
REQ-013 Pattern occurrences inside the payload SHALL NOT be detected, SHALL NOT restart the frame, and SHALL NOT increment match_cnt.
REQ-014 On entry to PAYLOAD, the history register and fill count SHALL be cleared, so that detection after a frame needs PAT_W fresh bits; payload bits SHALL NOT contribute to the history.
REQ-015 In HUNT, serOut and serOutValid SHALL be 0.
REQ-016 The frame counter SHALL never exceed FRAME_LEN-1 and SHALL NOT wrap.
REQ-017 Back-to-back patterns in HUNT SHALL follow overlapping-shift semantics until the first match; the first match wins.

Reset
REQ-018 While rst=0, the following SHALL be forced, asynchronously and regardless of clk:
- state = HUNT
- history = 0, fill count = 0, frame counter = 0
- serOut = 0, serOutValid = 0, frame_done = 0, match_cnt = 0
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse. After rst rises, the first edge SHALL be treated as the first bit of a fresh hunt.

Verification
REQ-020 The bench SHALL use PAT_W=6, PATTERN=6'b011110 and FRAME_LEN=8, and SHALL cover the following directed scenarios:
- Basic frame: serIn = 0,1,1,1,1,0 then payload 1,0,1,1,0,0,1,0 with en=1. Required: serOutValid is high for 8 cycles; serOut = 1,0,1,1,0,0,1,0, each one cycle after its input; frame_done pulses once; match_cnt=1.
- Pattern inside payload: send the pattern, then a payload containing 011110. Required: one frame of exactly 8 bits; match_cnt=1.
- en pauses: in PAYLOAD, hold en=0 for 3 cycles after payload bit 4. Required: serOutValid=0 for those 3 cycles; the total number of valid bits is still 8; frame_done occurs 3 cycles later than in the basic frame.
- Reset mid-frame: drive rst=0 after payload bit 5. Required: all outputs are 0 immediately; no frame_done; match_cnt=0. After release, a new pattern yields a full 8-bit frame.
- Near-miss and overlap: serIn = 0,1,1,1,0,1,1,1,1,0. Required: exactly one match, on the final 0. The payload starts with the next bit.
- Saturation: force 65536+ matches, or use a bench-visible parameter override. Required: match_cnt holds at 16'hFFFF.
